// File: rtl/zoom_pkg.sv
// rtl/zoom_pkg.sv - shared state encoding and default RAM geometry for the ZOOM line reader
package zoom_pkg;
    localparam int ZOOM_ADDR_WIDTH = 11;
    localparam int ZOOM_DATA_WIDTH = 16;
    localparam int ZOOM_RD_LATENCY = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } zoom_state_e;
endpackage

// File: rtl/zoom_skid_fifo.sv
// rtl/zoom_skid_fifo.sv - synchronous skid FIFO absorbing read data under downstream backpressure
module zoom_skid_fifo
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Storage is cleared too so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
endmodule

// File: rtl/zoom_line_reader.sv
// rtl/zoom_line_reader.sv - fetches one line from the ZOOM line RAM and streams it out with a last marker
module zoom_line_reader
    import zoom_pkg::*;
#(
    parameter int ADDR_WIDTH = ZOOM_ADDR_WIDTH,
    parameter int DATA_WIDTH = ZOOM_DATA_WIDTH,
    parameter int RD_LATENCY = ZOOM_RD_LATENCY,
    parameter int SKID_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   line_len,
    output logic                  busy,
    output logic                  done,
    input  logic                  ram_gnt,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr_en,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);
    localparam int CW = $clog2(SKID_DEPTH) + 1;

    zoom_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [ADDR_WIDTH:0]   remain_q, remain_d;
    logic [RD_LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic [RD_LATENCY-1:0] last_sr_q, last_sr_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic                  zero_done_q, zero_done_d;

    logic [CW-1:0]         fifo_count;
    logic                  fifo_full, fifo_empty;
    logic                  credit_ok, issue_now, final_issue;
    logic                  push, pop, head_last;
    logic [DATA_WIDTH-1:0] head_data;

    // Every beat in flight or buffered owns a FIFO slot, so a push can never find it full.
    assign credit_ok   = (int'(inflight_q) + int'(fifo_count) + 1) <= SKID_DEPTH;
    assign issue_now   = (state_q == ST_ISSUE) && ram_gnt && credit_ok;
    assign final_issue = issue_now && (remain_q == (ADDR_WIDTH+1)'(1));
    assign push        = vld_sr_q[RD_LATENCY-1];
    assign pop         = m_valid && m_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ram_addr_d  = ram_addr_q;
        remain_d    = remain_q;
        zero_done_d = (state_q == ST_DONE);
        vld_sr_d    = '0;
        last_sr_d   = '0;
        vld_sr_d[0]  = issue_now;
        last_sr_d[0] = final_issue;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_sr_d[i]  = vld_sr_q[i-1];
            last_sr_d[i] = last_sr_q[i-1];
        end
        inflight_d = inflight_q + CW'(issue_now) - CW'(push);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = line_len;
                    state_d  = (line_len == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue_now) begin
                    ram_addr_d = addr_q;
                    addr_d     = addr_q + ADDR_WIDTH'(1);
                    remain_d   = remain_q - (ADDR_WIDTH+1)'(1);
                    if (final_issue) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && head_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            ram_addr_q  <= '0;
            remain_q    <= '0;
            vld_sr_q    <= '0;
            last_sr_q   <= '0;
            inflight_q  <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ram_addr_q  <= ram_addr_d;
            remain_q    <= remain_d;
            vld_sr_q    <= vld_sr_d;
            last_sr_q   <= last_sr_d;
            inflight_q  <= inflight_d;
            zero_done_q <= zero_done_d;
        end
    end

    zoom_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({last_sr_q[RD_LATENCY-1], ram_rd_data}),
        .pop       (pop),
        .pop_data  ({head_last, head_data}),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = zero_done_q || ((state_q == ST_DRAIN) && pop && head_last);
    assign ram_addr  = ram_addr_q;
    assign ram_wr_en = 1'b0;
    assign m_valid   = !fifo_empty;
    assign m_data    = head_data;
    assign m_last    = head_last && m_valid;
endmodule
